// File: rtl/magnitude_compare_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : magnitude_compare_seq_if
//  Description : Request/response bundle for the sequential magnitude
//                comparator: start/operands in, busy/done/result flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface magnitude_compare_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    // Requesting logic drives operands and start, observes status and result
    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    // Comparator consumes the request and returns status and result
    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface
`default_nettype wire

// File: rtl/magnitude_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : magnitude_compare_seq
//  Description : Compares two WIDTH-bit unsigned operands two bits per cycle,
//                MSB slice first, stopping at the first unequal slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module magnitude_compare_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    magnitude_compare_seq_if.slave bus
);
    localparam int c_N     = WIDTH / 2;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);
    localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_gt;
    logic               r_eq;
    logic               r_lt;

    logic               w_accept;
    logic               w_last;
    logic [1:0]         w_a_sl;
    logic [1:0]         w_b_sl;

    // Requests are only taken while idle; anything else is dropped
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_idx == '0);

    // Current 2-bit slice: shift the operand down by twice the slice index
    assign w_a_sl = 2'(r_a >> {r_idx, 1'b0});
    assign w_b_sl = 2'(r_b >> {r_idx, 1'b0});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave COMPARE on the first unequal slice or the last slice
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if ((w_a_sl != w_b_sl) || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, slice index walk and result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_idx <= c_LAST;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            if (w_a_sl > w_b_sl) begin
                r_gt <= 1'b1;
            end else if (w_a_sl < w_b_sl) begin
                r_lt <= 1'b1;
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx - c_ONE;
            end
        end
    end

    // Status outputs are pure decodes of the state register
    assign bus.busy   = (r_state == S_COMPARE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.a_gt_b = r_gt;
    assign bus.a_eq_b = r_eq;
    assign bus.a_lt_b = r_lt;
endmodule
`default_nettype wire

// File: tb/tb_magnitude_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_magnitude_compare_seq
//  Description : Self-checking bench for magnitude_compare_seq (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_magnitude_compare_seq;
    localparam int c_W = 8;
    localparam int c_N = c_W / 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    magnitude_compare_seq_if #(.WIDTH(c_W)) ifc ();

    magnitude_compare_seq #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: {busy, done, gt, eq, lt}
    function automatic logic [4:0] obs();
        return {ifc.busy, ifc.done, ifc.a_gt_b, ifc.a_eq_b, ifc.a_lt_b};
    endfunction

    // Reference: slices examined = position of the first differing 2-bit
    // group counted from the top, or all of them when operands are equal
    function automatic int model_k(input logic [c_W-1:0] av, input logic [c_W-1:0] bv);
        logic [c_W-1:0] d;
        d = av ^ bv;
        for (int p = c_W - 1; p >= 0; p--) begin
            if (d[p]) return (c_W - 1 - p) / 2 + 1;
        end
        return c_N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (busy,done,gt,eq,lt)", tag, o, e);
        end
    endtask

    // One full request from IDLE; noisy mode keeps start high with random
    // operands while the comparison is running. hold = extra idle checks.
    task automatic do_cmp(input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                          input bit noise, input int hold, input string tag);
        int         k;
        logic [2:0] ef;
        k  = model_k(av, bv);
        ef = {av > bv, av == bv, av < bv};
        ifc.start = 1'b1;
        ifc.a     = av;
        ifc.b     = bv;
        tick();
        for (int c = 1; c <= k; c++) begin
            chk({tag, "_busy"}, obs(), 5'b10000);
            ifc.start = noise;
            ifc.a     = c_W'($urandom);
            ifc.b     = c_W'($urandom);
            tick();
        end
        chk({tag, "_done"}, obs(), {2'b01, ef});
        ifc.start = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            tick();
            chk({tag, "_hold"}, obs(), {2'b00, ef});
        end
    endtask

    initial begin
        logic [c_W-1:0] ra;
        logic [c_W-1:0] rb;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ifc.start = 1'b1;
        ifc.a     = c_W'($urandom);
        ifc.b     = c_W'($urandom);

        // Reset with start asserted: nothing may happen
        tick();
        chk("reset_e1", obs(), 5'b00000);
        tick();
        chk("reset_e2", obs(), 5'b00000);
        rst_n = 1'b1;
        do_cmp(8'h3C, 8'h3C, 1'b0, 0, "post_reset");

        // Directed cases
        do_cmp(8'hA5, 8'hA5, 1'b0, 2, "equal");
        do_cmp(8'h80, 8'h7F, 1'b0, 0, "early_gt");
        do_cmp(8'h34, 8'h37, 1'b0, 0, "lt_last");
        do_cmp(8'h00, 8'hFF, 1'b1, 1, "ignore_busy");
        do_cmp(8'hFF, 8'hFF, 1'b0, 0, "max_eq");
        do_cmp(8'h00, 8'h01, 1'b0, 0, "min_lt");

        // Reset in the middle of a comparison aborts without done
        ifc.start = 1'b1;
        ifc.a     = 8'h55;
        ifc.b     = 8'h55;
        tick();
        chk("midrst_c1", obs(), 5'b10000);
        ifc.start = 1'b0;
        tick();
        chk("midrst_c2", obs(), 5'b10000);
        rst_n = 1'b0;
        tick();
        chk("midrst_after", obs(), 5'b00000);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", obs(), 5'b00000);
        do_cmp(8'h55, 8'h55, 1'b0, 0, "midrst_new");

        // Randomised pairs, biased toward long common prefixes
        for (int t = 0; t < 40; t++) begin
            ra = c_W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ c_W'(1 << $urandom_range(0, c_W - 1));
                default: rb = c_W'($urandom);
            endcase
            do_cmp(ra, rb, 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
